// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32 front end: datapath widths,
// I-type immediate field position, PC step and the fetch-state encoding.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int INST_W    = 32;
    localparam int IMM_I_MSB = 31;
    localparam int IMM_I_LSB = 20;
    localparam int IMM_I_W   = IMM_I_MSB - IMM_I_LSB + 1;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE is only ever seen straight out of reset; the loop is REQ -> WAIT -> HOLD.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are always cleared.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_reg.sv
// Program counter register. Redirect wins over increment; the redirect
// target is word-aligned before it is loaded. Increment wraps modulo 2^32.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              incr_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Select the next PC: redirect target, sequential successor, or hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = align_pc(redirect_pc);
        end else if (incr_en) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    // PC state register.
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time,
// fetched word held for decode over valid/ready, redirects flush in-flight work.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [11:0]       imm12_out
);

    fetch_state_e        state_d, state_q;
    logic                drop_d, drop_q;
    logic [INST_W-1:0]   inst_d, inst_q;
    logic [ADDR_W-1:0]   inst_pc_d, inst_pc_q;
    logic [IMM_I_W-1:0]  imm12_d, imm12_q;
    logic                pc_incr;
    logic [ADDR_W-1:0]   pc;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (redirect_valid),
        .redirect_pc (redirect_pc),
        .incr_en     (pc_incr),
        .pc          (pc)
    );

    // Next-state, drop-flag and capture logic; redirect overrides every state.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        imm12_d        = imm12_q;
        pc_incr        = 1'b0;
        imem_req_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = WAIT;
                    // A request accepted alongside a redirect fetches the old path.
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_resp_valid) begin
                        // The outstanding response is consumed and discarded right now.
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc;
                        imm12_d   = imem_resp_data[IMM_I_MSB:IMM_I_LSB];
                        pc_incr   = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, drop flag and decode-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            imm12_q   <= '0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            imm12_q   <= imm12_d;
        end
    end

    assign imem_req_addr = pc;
    assign inst_valid    = (state_q == HOLD);
    assign inst_out      = inst_q;
    assign inst_pc       = inst_pc_q;
    assign imm12_out     = imm12_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage directly upstream of sign_extender in the RISC-V core. Holds the PC and issues one instruction-memory read at a time over a valid/ready request plus valid-only response. Presents the fetched instruction, its PC and the raw I-type immediate field (instr[31:20]) to decode over a valid/ready handshake. The immediate field feeds sign_extender._12_bit_immediate_in. Branch/jump redirects flush in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width; fixed at 32 for RV32

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (word-aligned)
imem_resp_valid  in  1  read data valid
imem_resp_data  in  32  read data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_out  out  32  fetched instruction
inst_pc  out  32  PC of inst_out
imm12_out  out  12  inst_out[31:20], to sign_extender

Behaviour:
- Reset: asynchronous on rst_n=0 (one clock, asynchronous active-low reset). pc=RESET_PC, state=IDLE, drop=0. imem_req_valid=0, imem_req_addr=RESET_PC. inst_valid=0, inst_out=0, inst_pc=0, imm12_out=0.
- IDLE: entered only from reset; moves to REQ on the first clock edge with rst_n=1.
- REQ: imem_req_valid=1, imem_req_addr=pc. Address held stable until accepted; it changes only on redirect. When imem_req_ready=1, move to WAIT.
- WAIT: imem_req_valid=0. Exactly one request is outstanding. On imem_resp_valid with drop=0: register inst_out=data, inst_pc=pc, imm12_out=data[31:20]; pc<=pc+4; move to HOLD.
- HOLD: inst_valid=1 with all outputs stable. On inst_ready=1, move to REQ the next cycle; inst_valid drops.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT with a 1-cycle response, HOLD). Responses count only in WAIT, never in the acceptance cycle. imem_resp_valid outside WAIT is ignored, including stale responses after a mid-operation reset.
- PC arithmetic: modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000. redirect_pc[1:0] is forced to 2'b00.
- Redirect has the highest priority in every state; pc<=redirect_pc aligned.
  - IDLE: pc updated, then to REQ.
  - REQ, no ready that cycle: stay in REQ; addr=new pc next cycle.
  - REQ with imem_req_ready=1 the same cycle: move to WAIT with drop=1.
  - WAIT: drop=1. A response arriving in the same cycle is discarded.
  - HOLD: held instruction discarded even if inst_ready=1 the same cycle; inst_valid=0 next cycle; move to REQ.
- drop=1 in WAIT: the next response is discarded, drop clears, move to REQ. Outputs and pc are not updated by the discarded response.
- inst_ready while inst_valid=0 has no effect.

Decomposition:
- Package riscv_pkg holds: XLEN=32, INST_W=32, IMM_I_MSB=31, IMM_I_LSB=20, PC_STEP=4, DEFAULT_RESET_PC, and the fetch-state enum (IDLE, REQ, WAIT, HOLD).
- One sub-module, pc_reg: async-reset PC register with increment/redirect select and alignment masking.
- FSM, drop flag and output registers live in the top level.

Test Plan:
- Reset release, RESET_PC=0, ready=1, 1-cycle response 32'h0050_0093 -> req addr 0 on cycle 1; inst_valid cycle 3 with inst_out=32'h0050_0093, inst_pc=0, imm12_out=12'h005.
- Response 32'hFFF0_0113 (addi sp,x0,-1) -> imm12_out=12'hFFF; next fetch addr=4.
- Decode stalls (inst_ready=0) 5 cycles -> outputs stable, no new request; ready=1 -> REQ next cycle with addr=pc+4.
- Redirect to 32'h0000_0103 while in WAIT; response 32'hDEAD_BEEF arrives -> response discarded, inst_valid stays 0, next req addr=32'h0000_0100.
- Redirect in HOLD coincident with inst_ready=1 -> instruction not counted, inst_valid=0 next cycle, req addr=redirect target.
- PC=32'hFFFF_FFFC fetch completes -> next req addr=32'h0000_0000. Async rst_n pulse in WAIT, then a late resp_valid -> ignored; outputs zero, req addr=RESET_PC.
